// File: rtl/ksort_query_ctrl_pkg.sv
// Shared definitions for the k-smallest query controller and its kSorting
// companion: default sorter geometry, the controller state encoding and a
// small helper for clamping the requested result count.
package ksort_query_ctrl_pkg;

  // Defaults shared with kSorting (dataWidth / maxMemory).
  localparam int unsigned KSQ_DATA_WIDTH = 32;
  localparam int unsigned KSQ_MAX_MEMORY = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } ksq_state_e;

  // Smallest of three unsigned 32-bit quantities.
  function automatic logic [31:0] ksq_min3(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] c);
    logic [31:0] m;
    m = (a < b) ? a : b;
    m = (m < c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/ksort_query_ctrl.sv
// ksort_query_ctrl
//   Sequences one kSorting instance for a k-smallest query: clears the
//   sorter, streams cfg_n (name,value) items into it, then drains the
//   min(cfg_k, cfg_n, MAX_MEMORY) smallest in ascending order through a
//   valid/ready port.
// Ports
//   clk, reset          : clock (rising edge), asynchronous active-low reset
//   start, cfg_k, cfg_n : query launch and configuration (sampled in IDLE)
//   busy, q_done        : status; q_done is a one-cycle completion pulse
//   in_*                : item stream into the sorter (valid/ready)
//   out_*               : result stream (valid/ready), data straight from sorter
//   sort_*              : control/data towards kSorting
//   sort_*_out          : current result from kSorting
module ksort_query_ctrl
  import ksort_query_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = KSQ_DATA_WIDTH,
  parameter int unsigned MAX_MEMORY = KSQ_MAX_MEMORY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           cfg_k,
  input  logic [31:0]           cfg_n,
  output logic                  busy,
  output logic                  q_done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_name,
  input  logic [DATA_WIDTH-1:0] in_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_name,
  output logic [DATA_WIDTH-1:0] out_value,
  output logic                  sort_reset,
  output logic                  sort_valid,
  output logic                  sort_done,
  output logic [31:0]           sort_k,
  output logic [31:0]           sort_name,
  output logic [DATA_WIDTH-1:0] sort_value,
  input  logic [31:0]           sort_name_out,
  input  logic [DATA_WIDTH-1:0] sort_value_out
);

  ksq_state_e            state_q, state_d;
  logic [31:0]           k_eff_q, k_eff_d;
  logic [31:0]           n_lat_q, n_lat_d;
  logic [31:0]           in_cnt_q, in_cnt_d;
  logic [31:0]           out_cnt_q, out_cnt_d;
  logic                  sort_valid_q, sort_valid_d;
  logic [31:0]           sort_name_q, sort_name_d;
  logic [DATA_WIDTH-1:0] sort_value_q, sort_value_d;
  logic                  sort_reset_q, sort_reset_d;
  logic                  busy_q, busy_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  q_done_q, q_done_d;
  logic                  in_accept;
  logic                  out_accept;

  always_comb begin
    state_d      = state_q;
    k_eff_d      = k_eff_q;
    n_lat_d      = n_lat_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    sort_valid_d = 1'b0;
    sort_name_d  = sort_name_q;
    sort_value_d = sort_value_q;
    in_accept    = in_valid & in_ready_q;
    out_accept   = out_valid_q & out_ready;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CLEAR;
          k_eff_d   = ksq_min3(cfg_k, cfg_n, 32'(MAX_MEMORY));
          n_lat_d   = cfg_n;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        state_d = (n_lat_q != '0) ? ST_LOAD : ST_DONE;
      end
      ST_LOAD: begin
        if (in_accept) begin
          sort_name_d  = in_name;
          sort_value_d = in_value;
          sort_valid_d = 1'b1;
          in_cnt_d     = in_cnt_q + 32'd1;
          if (in_cnt_q == n_lat_q - 32'd1) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        // The last item is presented to the sorter during this cycle.
        state_d = (k_eff_q != '0) ? ST_DRAIN : ST_DONE;
      end
      ST_DRAIN: begin
        if (out_accept) begin
          out_cnt_d = out_cnt_q + 32'd1;
          if (out_cnt_q == k_eff_q - 32'd1) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered by decoding the next state.
    busy_d       = (state_d != ST_IDLE);
    in_ready_d   = (state_d == ST_LOAD);
    out_valid_d  = (state_d == ST_DRAIN);
    q_done_d     = (state_d == ST_DONE);
    sort_reset_d = (state_d == ST_IDLE) || (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      k_eff_q      <= '0;
      n_lat_q      <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      sort_valid_q <= 1'b0;
      sort_name_q  <= '0;
      sort_value_q <= '0;
      sort_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      q_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_eff_q      <= k_eff_d;
      n_lat_q      <= n_lat_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      sort_valid_q <= sort_valid_d;
      sort_name_q  <= sort_name_d;
      sort_value_q <= sort_value_d;
      sort_reset_q <= sort_reset_d;
      busy_q       <= busy_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      q_done_q     <= q_done_d;
    end
  end

  assign busy       = busy_q;
  assign q_done     = q_done_q;
  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_name   = sort_name_out;
  assign out_value  = sort_value_out;
  assign sort_reset = sort_reset_q;
  assign sort_valid = sort_valid_q;
  // Sorter pointer has no backpressure: advance exactly once per accepted result.
  assign sort_done  = out_accept;
  assign sort_k     = k_eff_q;
  assign sort_name  = sort_name_q;
  assign sort_value = sort_value_q;

endmodule

// File: tb/tb_ksort_query_ctrl.sv
module tb_ksort_query_ctrl;
  import ksort_query_ctrl_pkg::*;

  localparam int DW   = 32;
  localparam int MEMD = 8;

  typedef struct packed {
    logic [31:0]   name;
    logic [DW-1:0] value;
  } item_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   cfg_k, cfg_n;
  logic          busy, q_done;
  logic          in_valid, in_ready;
  logic [31:0]   in_name;
  logic [DW-1:0] in_value;
  logic          out_valid, out_ready;
  logic [31:0]   out_name;
  logic [DW-1:0] out_value;
  logic          sort_reset, sort_valid, sort_done;
  logic [31:0]   sort_k, sort_name;
  logic [DW-1:0] sort_value;
  logic [31:0]   sort_name_out;
  logic [DW-1:0] sort_value_out;

  ksort_query_ctrl #(.DATA_WIDTH(DW), .MAX_MEMORY(MEMD)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_k(cfg_k), .cfg_n(cfg_n),
    .busy(busy), .q_done(q_done), .in_valid(in_valid), .in_ready(in_ready),
    .in_name(in_name), .in_value(in_value), .out_valid(out_valid),
    .out_ready(out_ready), .out_name(out_name), .out_value(out_value),
    .sort_reset(sort_reset), .sort_valid(sort_valid), .sort_done(sort_done),
    .sort_k(sort_k), .sort_name(sort_name), .sort_value(sort_value),
    .sort_name_out(sort_name_out), .sort_value_out(sort_value_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural kSorting: sorted ascending store, empty slots hold all-ones,
  // read pointer advanced by sort_done, synchronous clear on sort_reset.
  logic [31:0]   m_name [MEMD];
  logic [DW-1:0] m_val  [MEMD];
  int            m_ptr;
  int            ins_pos;

  function automatic int find_pos(input logic [DW-1:0] v);
    int p;
    p = MEMD;
    for (int i = MEMD - 1; i >= 0; i--) if (m_val[i] > v) p = i;
    return p;
  endfunction

  always @(posedge clk) begin
    if (sort_reset) begin
      for (int i = 0; i < MEMD; i++) begin
        m_val[i]  <= '1;
        m_name[i] <= '1;
      end
      m_ptr <= 0;
    end else begin
      if (sort_valid) begin
        ins_pos = find_pos(sort_value);
        for (int i = 0; i < MEMD; i++) begin
          if (i > ins_pos) begin
            m_val[i]  <= m_val[i-1];
            m_name[i] <= m_name[i-1];
          end else if (i == ins_pos) begin
            m_val[i]  <= sort_value;
            m_name[i] <= sort_name;
          end
        end
      end
      if (sort_done) m_ptr <= m_ptr + 1;
    end
  end

  assign sort_value_out = (m_ptr < MEMD) ? m_val[m_ptr]  : '1;
  assign sort_name_out  = (m_ptr < MEMD) ? m_name[m_ptr] : '1;

  // Checking and scoreboard
  int    checks   = 0;
  int    failures = 0;
  item_t exp_q[$];
  int    hs_cnt = 0, done_cnt = 0, valid_cycles = 0, done_cyc = 0;
  bit    stall_mode = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_rst_busy"},       64'(busy),       64'd0);
    check_eq({tag, "_rst_q_done"},     64'(q_done),     64'd0);
    check_eq({tag, "_rst_in_ready"},   64'(in_ready),   64'd0);
    check_eq({tag, "_rst_out_valid"},  64'(out_valid),  64'd0);
    check_eq({tag, "_rst_sort_reset"}, 64'(sort_reset), 64'd1);
    check_eq({tag, "_rst_sort_valid"}, 64'(sort_valid), 64'd0);
    check_eq({tag, "_rst_sort_k"},     64'(sort_k),     64'd0);
    check_eq({tag, "_rst_sort_name"},  64'(sort_name),  64'd0);
    check_eq({tag, "_rst_sort_value"}, 64'(sort_value), 64'd0);
  endtask

  // Consumer side: out_ready pattern
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = stall_mode ? ~out_ready : 1'b1;
    end
  end

  // Monitor: samples 1 time unit after the falling edge, when this cycle's
  // inputs are settled and outputs are stable.
  initial begin
    item_t         e;
    bit            held = 1'b0;
    logic [31:0]   held_name;
    logic [DW-1:0] held_val;
    bit            pend = 1'b0;
    logic [DW-1:0] pend_val;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        held = 1'b0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          check_eq("sort_valid_delayed", 64'(sort_valid), 64'd1);
          check_eq("sort_value_delayed", 64'(sort_value), 64'(pend_val));
        end else if (sort_valid) begin
          check_eq("sort_valid_spurious", 64'(sort_valid), 64'd0);
        end
        pend     = in_valid & in_ready;
        pend_val = in_value;

        if (out_valid) begin
          valid_cycles++;
          if (held) begin
            check_eq("stall_hold_value", 64'(out_value), 64'(held_val));
            check_eq("stall_hold_name",  64'(out_name),  64'(held_name));
          end
          if (out_ready) begin
            held = 1'b0;
            hs_cnt++;
            if (exp_q.size() == 0) begin
              check_eq("unexpected_output", 64'(out_value), 64'h1_0000_0000);
            end else begin
              e = exp_q.pop_front();
              check_eq("out_value", 64'(out_value), 64'(e.value));
              check_eq("out_name",  64'(out_name),  64'(e.name));
            end
          end else begin
            held      = 1'b1;
            held_val  = out_value;
            held_name = out_name;
          end
        end else begin
          held = 1'b0;
        end
        if (q_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic run_query(input string tag, input int unsigned k, input int unsigned n,
                           input logic [DW-1:0] vals[$], input bit inject_start,
                           input int abort_after);
    item_t       srt[$];
    item_t       it;
    int unsigned keff;
    int          p, idx, guard, hs0, dc0, vc0, start_cyc;
    logic        rdy;
    bit          aborted;

    keff = k;
    if (n < keff) keff = n;
    if (MEMD < keff) keff = MEMD;
    for (int i = 0; i < int'(n); i++) begin
      it.name  = 32'h100 + 32'(i);
      it.value = vals[i];
      p = srt.size();
      for (int j = srt.size() - 1; j >= 0; j--) if (srt[j].value > it.value) p = j;
      srt.insert(p, it);
    end
    for (int i = 0; i < int'(keff); i++) exp_q.push_back(srt[i]);
    hs0 = hs_cnt;
    dc0 = done_cnt;
    vc0 = valid_cycles;

    @(negedge clk);
    cfg_k     = k;
    cfg_n     = n;
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;

    idx   = 0;
    guard = 0;
    while (idx < int'(n) && guard < 1000) begin
      in_valid = 1'b1;
      in_name  = 32'h100 + 32'(idx);
      in_value = vals[idx];
      if (inject_start && idx == 2) begin
        start = 1'b1;
        cfg_k = 1;
        cfg_n = 2;
      end
      rdy = in_ready;
      @(negedge clk);
      start = 1'b0;
      if (rdy) idx++;
      guard++;
    end
    in_valid = 1'b0;
    check_eq({tag, "_load_in_time"}, 64'(guard < 1000), 64'd1);

    guard   = 0;
    aborted = 1'b0;
    while (done_cnt == dc0 && guard < 500 && !aborted) begin
      @(negedge clk);
      #2;
      guard++;
      if (abort_after >= 0 && hs_cnt - hs0 >= abort_after) begin
        reset   = 1'b0;
        aborted = 1'b1;
      end
    end

    if (aborted) begin
      #1;
      check_reset_state(tag);
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      return;
    end

    check_eq({tag, "_done_in_time"}, 64'(guard < 500), 64'd1);
    repeat (3) @(negedge clk);
    #2;
    check_eq({tag, "_q_done_once"}, 64'(done_cnt - dc0), 64'd1);
    check_eq({tag, "_out_count"},   64'(hs_cnt - hs0),   64'(keff));
    check_eq({tag, "_sb_empty"},    64'(exp_q.size()),   64'd0);
    check_eq({tag, "_sort_k"},      64'(sort_k),         64'(keff));
    check_eq({tag, "_idle"},        64'(busy),           64'd0);
    if (keff == 0) check_eq({tag, "_no_valid"}, 64'(valid_cycles - vc0), 64'd0);
    if (n == 0)    check_eq({tag, "_done_le4"}, 64'(done_cyc - start_cyc <= 4), 64'd1);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] vals[$];
    reset    = 1'b0;
    start    = 1'b0;
    cfg_k    = '0;
    cfg_n    = '0;
    in_valid = 1'b0;
    in_name  = '0;
    in_value = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_state("init");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    vals = '{50, 10, 40, 20, 30};
    run_query("t1_basic", 3, 5, vals, 1'b0, -1);

    stall_mode = 1'b1;
    run_query("t2_stall", 3, 5, vals, 1'b0, -1);
    stall_mode = 1'b0;

    vals = '{7, 3, 9, 1};
    run_query("t3_k_gt_n", 10, 4, vals, 1'b0, -1);

    vals = {};
    run_query("t4_n0", 5, 0, vals, 1'b0, -1);
    vals = '{5, 6, 7};
    run_query("t4_k0", 0, 3, vals, 1'b0, -1);

    vals = '{50, 10, 40, 20, 30};
    run_query("t5_abort", 3, 5, vals, 1'b0, 2);
    vals = '{15, 5, 25, 35, 45};
    run_query("t5_fresh", 3, 5, vals, 1'b0, -1);

    vals = '{60, 90, 70, 80, 65};
    run_query("t6_start_busy", 3, 5, vals, 1'b1, -1);

    vals = '{33, 12, 99, 4, 57, 21, 8, 76, 45, 2};
    run_query("t7_clamp", 20, 10, vals, 1'b0, -1);

    stall_mode = 1'b1;
    run_query("t8_clamp_stall", 20, 10, vals, 1'b0, -1);
    stall_mode = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
